// File: rtl/race_tree_ctrl.sv
// Multi-lane drag-race start tree: red, sequential or simultaneous amber stages, green,
// with per-lane false-start detection and reaction-time capture. Every output is a flop.
module race_tree_ctrl #(
  parameter int unsigned LANES       = 2,
  parameter int unsigned AMBERS      = 3,
  parameter int unsigned AMBER_TICKS = 8,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   pro_mode,
  input  logic [LANES-1:0]       staged,
  input  logic [LANES-1:0]       launch,
  output logic                   red,
  output logic [AMBERS-1:0]      amber,
  output logic                   green,
  output logic [LANES-1:0]       foul,
  output logic [LANES-1:0]       react_valid,
  output logic [LANES*CNT_W-1:0] react_time,
  output logic                   busy
);

  localparam int unsigned STEP_W = (AMBERS > 1) ? $clog2(AMBERS) : 1;
  localparam int unsigned TICK_W = (AMBER_TICKS > 1) ? $clog2(AMBER_TICKS) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(AMBERS - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(AMBER_TICKS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_STAGE_WAIT, S_AMBER, S_GREEN, S_DONE
  } state_t;

  state_t                   state, state_nx;
  logic [STEP_W-1:0]        step, step_nx;
  logic [TICK_W-1:0]        tick, tick_nx;
  logic [CNT_W-1:0]         cnt, cnt_nx;
  logic                     pro, pro_nx;
  logic [LANES-1:0]         foul_nx, react_valid_nx;
  logic [LANES*CNT_W-1:0]   react_time_nx;
  logic                     red_nx, green_nx, busy_nx;
  logic [AMBERS-1:0]        amber_nx;

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      step        <= '0;
      tick        <= '0;
      cnt         <= '0;
      pro         <= 1'b0;
      red         <= 1'b1;
      amber       <= '0;
      green       <= 1'b0;
      foul        <= '0;
      react_valid <= '0;
      react_time  <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nx;
      step        <= step_nx;
      tick        <= tick_nx;
      cnt         <= cnt_nx;
      pro         <= pro_nx;
      red         <= red_nx;
      amber       <= amber_nx;
      green       <= green_nx;
      foul        <= foul_nx;
      react_valid <= react_valid_nx;
      react_time  <= react_time_nx;
      busy        <= busy_nx;
    end
  end

  // Next state, counters, lane results; lights are decoded from the next state
  always_comb begin
    state_nx       = state;
    step_nx        = step;
    tick_nx        = tick;
    cnt_nx         = cnt;
    pro_nx         = pro;
    foul_nx        = foul;
    react_valid_nx = react_valid;
    react_time_nx  = react_time;
    red_nx         = 1'b0;
    amber_nx       = '0;
    green_nx       = 1'b0;
    busy_nx        = 1'b0;

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nx       = S_STAGE_WAIT;
          pro_nx         = pro_mode;
          foul_nx        = '0;
          react_valid_nx = '0;
          react_time_nx  = '0;
        end
      end
      S_STAGE_WAIT: begin
        if (&staged) begin
          state_nx = S_AMBER;
          step_nx  = '0;
          tick_nx  = '0;
        end
      end
      S_AMBER: begin
        foul_nx = foul | launch;
        if (tick == TICK_LAST) begin
          tick_nx = '0;
          if (pro || step == STEP_LAST) begin
            state_nx = S_GREEN;
            cnt_nx   = '0;
          end else begin
            step_nx = step + STEP_W'(1);
          end
        end else begin
          tick_nx = tick + TICK_W'(1);
        end
      end
      S_GREEN: begin
        for (int i = 0; i < LANES; i++) begin
          if (launch[i] && !foul[i] && !react_valid[i]) begin
            react_valid_nx[i]            = 1'b1;
            react_time_nx[i*CNT_W +: CNT_W] = cnt;
          end
        end
        cnt_nx = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
        // Same-edge captures count, so a fully resolved race lands in DONE immediately
        if ((&(foul | react_valid_nx)) || cnt == CNT_MAX) begin
          state_nx = S_DONE;
        end
      end
      default: state_nx = S_IDLE;
    endcase

    case (state_nx)
      S_IDLE:       red_nx = 1'b1;
      S_STAGE_WAIT: begin
        red_nx  = 1'b1;
        busy_nx = 1'b1;
      end
      S_AMBER: begin
        amber_nx = pro_nx ? '1 : (AMBERS'(1) << step_nx);
        busy_nx  = 1'b1;
      end
      S_GREEN: begin
        green_nx = 1'b1;
        busy_nx  = 1'b1;
      end
      S_DONE:       red_nx = |foul_nx;
      default:      red_nx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_race_tree_ctrl.sv
// Randomized and directed bench for race_tree_ctrl against a phase/time reference model.
module tb_race_tree_ctrl;

  localparam int unsigned LANES = 2;
  localparam int unsigned AMBERS = 3;
  localparam int unsigned AT = 4;
  localparam int unsigned CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic pro_mode = 1'b0;
  logic [LANES-1:0] staged = '0;
  logic [LANES-1:0] launch = '0;
  logic red, green, busy;
  logic [AMBERS-1:0] amber;
  logic [LANES-1:0] foul, react_valid;
  logic [LANES*CNT_W-1:0] react_time;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: race phase (0 idle, 1 waiting, 2 running, 3 done) and time since amber began
  int m_ph;
  int m_t;
  bit m_pro;
  bit [LANES-1:0] m_foul, m_rv;
  int m_rt [LANES];

  always #5 clk = ~clk;

  race_tree_ctrl #(
    .LANES(LANES), .AMBERS(AMBERS), .AMBER_TICKS(AT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pro_mode(pro_mode),
    .staged(staged), .launch(launch), .red(red), .amber(amber),
    .green(green), .foul(foul), .react_valid(react_valid),
    .react_time(react_time), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h want %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = 0;
    m_t = 0;
    m_pro = 1'b0;
    m_foul = '0;
    m_rv = '0;
    for (int i = 0; i < LANES; i++) m_rt[i] = 0;
  endtask

  function automatic int amber_len(input bit p);
    return p ? AT : AMBERS * AT;
  endfunction

  task automatic model_step(input bit s, input bit p, input bit [LANES-1:0] stg,
                            input bit [LANES-1:0] lch);
    int r;
    case (m_ph)
      0, 3: if (s) begin
        m_ph = 1;
        m_pro = p;
        m_foul = '0;
        m_rv = '0;
        for (int i = 0; i < LANES; i++) m_rt[i] = 0;
      end
      1: if (stg == '1) begin
        m_ph = 2;
        m_t = 0;
      end
      2: begin
        if (m_t < amber_len(m_pro)) begin
          m_foul = m_foul | lch;
          m_t++;
        end else begin
          r = m_t - amber_len(m_pro);
          for (int i = 0; i < LANES; i++)
            if (lch[i] && !m_foul[i] && !m_rv[i]) begin
              m_rv[i] = 1'b1;
              m_rt[i] = r;
            end
          if ((m_foul | m_rv) == '1 || r == CNT_MAX) m_ph = 3;
          else m_t++;
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_all();
    logic e_red, e_grn, e_busy;
    logic [AMBERS-1:0] e_amb;
    logic [LANES*CNT_W-1:0] e_rt;
    e_red = 1'b0;
    e_grn = 1'b0;
    e_busy = 1'b0;
    e_amb = '0;
    case (m_ph)
      0: e_red = 1'b1;
      1: begin e_red = 1'b1; e_busy = 1'b1; end
      2: begin
        e_busy = 1'b1;
        if (m_t < amber_len(m_pro)) e_amb = m_pro ? '1 : AMBERS'(1 << (m_t / AT));
        else e_grn = 1'b1;
      end
      default: e_red = |m_foul;
    endcase
    for (int i = 0; i < LANES; i++) e_rt[i*CNT_W +: CNT_W] = CNT_W'(m_rt[i]);
    chk("red", 32'(red), 32'(e_red));
    chk("amber", 32'(amber), 32'(e_amb));
    chk("green", 32'(green), 32'(e_grn));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("foul", 32'(foul), 32'(m_foul));
    chk("react_valid", 32'(react_valid), 32'(m_rv));
    chk("react_time", 32'(react_time), 32'(e_rt));
  endtask

  // One clock: drive inputs, advance the model, then check just after the edge
  task automatic step(input bit s, input bit p, input bit [LANES-1:0] stg,
                      input bit [LANES-1:0] lch);
    start = s;
    pro_mode = p;
    staged = stg;
    launch = lch;
    model_step(s, p, stg, lch);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic async_reset();
    #2;
    reset = 1'b0;
    start = 1'b0;
    staged = '0;
    launch = '0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #1 reset = 1'b0;
    #1 check_all();
    @(negedge clk);
    reset = 1'b1;

    // Full tree, lane1 reacts in green cycle 0, lane0 in cycle 5; start in GREEN ignored
    step(1, 0, 2'b00, 2'b00);
    step(0, 0, 2'b11, 2'b00);
    repeat (11) step(0, 0, 2'b00, 2'b00);
    chk("t1_last_amber", 32'(amber), 32'h4);
    step(0, 0, 2'b00, 2'b00);
    chk("t1_green_c13", 32'(green), 32'h1);
    step(0, 0, 2'b00, 2'b10);
    step(0, 0, 2'b00, 2'b00);
    step(1, 1, 2'b00, 2'b00);
    repeat (2) step(0, 0, 2'b00, 2'b00);
    step(0, 0, 2'b00, 2'b01);
    chk("t1_rt", 32'(react_time), 32'h05);
    chk("t1_rv", 32'(react_valid), 32'h3);
    chk("t1_red", 32'(red), 32'h0);

    // Pro tree: amber all on for exactly AT cycles; both lanes resolve on one edge
    step(1, 1, 2'b00, 2'b00);
    step(0, 0, 2'b11, 2'b00);
    repeat (3) step(0, 0, 2'b00, 2'b00);
    chk("t2_pro_amber", 32'(amber), 32'h7);
    step(0, 0, 2'b00, 2'b00);
    chk("t2_green", 32'(green), 32'h1);
    step(0, 0, 2'b00, 2'b11);
    chk("t2_done", 32'(busy), 32'h0);

    // Foul on lane1 during amber step 1
    step(1, 0, 2'b00, 2'b00);
    step(0, 0, 2'b11, 2'b00);
    repeat (4) step(0, 0, 2'b00, 2'b00);
    step(0, 0, 2'b00, 2'b10);
    chk("t3_foul", 32'(foul), 32'h2);
    repeat (9) step(0, 0, 2'b00, 2'b00);
    step(0, 0, 2'b00, 2'b11);
    chk("t3_red", 32'(red), 32'h1);
    chk("t3_rv", 32'(react_valid), 32'h1);

    // Timeout with no launches: 16 green cycles
    step(1, 0, 2'b00, 2'b00);
    step(0, 0, 2'b11, 2'b00);
    repeat (12 + 15) step(0, 0, 2'b00, 2'b00);
    chk("t4_green_16", 32'(green), 32'h1);
    step(0, 0, 2'b00, 2'b00);
    chk("t4_rv", 32'(react_valid), 32'h0);
    chk("t4_red", 32'(red), 32'h0);

    // Launch in last amber cycle fouls; launch in first green cycle reacts 0
    step(1, 0, 2'b00, 2'b00);
    step(0, 0, 2'b11, 2'b00);
    repeat (11) step(0, 0, 2'b00, 2'b00);
    step(0, 0, 2'b00, 2'b01);
    step(0, 0, 2'b00, 2'b10);
    chk("t5_foul", 32'(foul), 32'h1);
    chk("t5_rv", 32'(react_valid), 32'h2);

    // Async reset during amber step 2, then a clean race
    step(1, 0, 2'b00, 2'b00);
    step(0, 0, 2'b11, 2'b00);
    repeat (9) step(0, 0, 2'b00, 2'b00);
    async_reset();
    step(1, 0, 2'b00, 2'b00);
    step(0, 0, 2'b11, 2'b00);
    repeat (14) step(0, 0, 2'b00, 2'b00);
    step(0, 0, 2'b00, 2'b11);

    // Randomized races
    for (int n = 0; n < 3000; n++) begin
      bit s, p;
      bit [LANES-1:0] stg, lch;
      s = ($urandom_range(0, 5) == 0);
      p = $urandom_range(0, 1) == 1;
      stg = ($urandom_range(0, 2) == 0) ? '1 : LANES'($urandom);
      for (int i = 0; i < LANES; i++) lch[i] = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 399) == 0) async_reset();
      step(s, p, stg, lch);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
